harvard_mem_ctrl: RTL and testbench

HARVARD_MEM_CTRL -- requirements
Module: harvard_mem_ctrl

---
 rtl/harvard_mem_pkg.sv | 16 +
 rtl/mem_port_fsm.sv | 110 +++++++++++
 rtl/harvard_mem_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_harvard_mem_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/harvard_mem_pkg.sv
// Shared types and constants for the Harvard memory controller.
// The per-port handshake state type and the wait-state counter width
// live here so the top level and the port FSM agree on them.
package harvard_mem_pkg;

    // Width of the wait-state counter (WAIT_CYCLES range 0..15)
    localparam int CNT_W = 4;

    // Per-port access state: accept, count wait states, hold response
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } port_state_t;

endpackage

// File: rtl/mem_port_fsm.sv
// Handshake FSM and wait-state counter for one memory port.
// accept pulses on the edge a request is taken; enter_resp pulses on the
// edge the port moves into RESP, which is when the top level samples or
// commits the array. Both strobes are combinational from registered state.
module mem_port_fsm
    import harvard_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic req_valid,
    input  logic rsp_ready,
    output logic req_ready,
    output logic rsp_valid,
    output logic accept,
    output logic enter_resp
);

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    port_state_t      state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             req_ready_r;
    logic             rsp_valid_r;
    logic             accept_s;
    logic             enter_resp_s;

    // Decode the accept and response-entry strobes for this cycle
    always_comb begin
        accept_s     = 1'b0;
        enter_resp_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid && !rst) begin
                    accept_s     = 1'b1;
                    enter_resp_s = (WAIT_LOAD == CNT_ZERO);
                end else begin
                    accept_s     = 1'b0;
                    enter_resp_s = 1'b0;
                end
            end
            WAIT: begin
                enter_resp_s = (cnt_r == CNT_ZERO);
            end
            RESP: begin
                enter_resp_s = 1'b0;
            end
            default: begin
                accept_s     = 1'b0;
                enter_resp_s = 1'b0;
            end
        endcase
    end

    // Port state machine, wait counter and registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= CNT_ZERO;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        req_ready_r <= 1'b0;
                        if (enter_resp_s) begin
                            state_r     <= RESP;
                            cnt_r       <= CNT_ZERO;
                            rsp_valid_r <= 1'b1;
                        end else begin
                            state_r <= WAIT;
                            cnt_r   <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_r == CNT_ZERO) begin
                        state_r     <= RESP;
                        rsp_valid_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_r     <= IDLE;
                        rsp_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cnt_r       <= CNT_ZERO;
                    req_ready_r <= 1'b1;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_r;
    assign rsp_valid  = rsp_valid_r;
    assign accept     = accept_s;
    assign enter_resp = enter_resp_s;

endmodule

// File: rtl/harvard_mem_ctrl.sv
// Harvard memory controller: separate instruction (read-only) and data
// (read/write) arrays, each behind its own valid/ready port with a fixed
// number of wait states. The arrays live here; the handshake sequencing is
// delegated to two mem_port_fsm instances.
// Optional feature: define HMEM_BYTE_WRITE_EN to add the d_be byte-enable
// port; without it data writes always update the full word.
module harvard_mem_ctrl
    import harvard_mem_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int ADDRSIZE    = 12,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req_valid,
    output logic                i_req_ready,
    input  logic [ADDRSIZE-1:0] i_addr,
    output logic                i_rsp_valid,
    input  logic                i_rsp_ready,
    output logic [WIDTH-1:0]    i_rdata,
    input  logic                d_req_valid,
    output logic                d_req_ready,
    input  logic [ADDRSIZE-1:0] d_addr,
    input  logic                d_we,
    input  logic [WIDTH-1:0]    d_wdata,
`ifdef HMEM_BYTE_WRITE_EN
    input  logic [WIDTH/8-1:0]  d_be,
`endif
    output logic                d_rsp_valid,
    input  logic                d_rsp_ready,
    output logic [WIDTH-1:0]    d_rdata
);

    localparam int DEPTH = 2 ** ADDRSIZE;
    localparam int NB    = WIDTH / 8;

    logic [WIDTH-1:0] i_mem [DEPTH];
    logic [WIDTH-1:0] d_mem [DEPTH];

    logic                i_accept_s;
    logic                i_enter_resp_s;
    logic [ADDRSIZE-1:0] i_addr_r;
    logic [ADDRSIZE-1:0] i_acc_addr_s;
    logic [WIDTH-1:0]    i_rdata_r;

    logic                d_accept_s;
    logic                d_enter_resp_s;
    logic [ADDRSIZE-1:0] d_addr_r;
    logic                d_we_r;
    logic [WIDTH-1:0]    d_wdata_r;
    logic [ADDRSIZE-1:0] d_acc_addr_s;
    logic                d_acc_we_s;
    logic [WIDTH-1:0]    d_acc_wdata_s;
    logic [WIDTH-1:0]    d_wr_word_s;
    logic [WIDTH-1:0]    d_rdata_r;

`ifdef HMEM_BYTE_WRITE_EN
    logic [NB-1:0]       d_be_r;
    logic [NB-1:0]       d_acc_be_s;

    // Replace only the byte lanes whose enable bit is set
    function automatic logic [WIDTH-1:0] merge_bytes(
        input logic [WIDTH-1:0] old_word,
        input logic [WIDTH-1:0] new_word,
        input logic [NB-1:0]    be
    );
        logic [WIDTH-1:0] res;
        res = old_word;
        for (int b = 0; b < NB; b++) begin
            if (be[b]) begin
                res[b*8 +: 8] = new_word[b*8 +: 8];
            end else begin
                res[b*8 +: 8] = old_word[b*8 +: 8];
            end
        end
        return res;
    endfunction
`endif

    mem_port_fsm #(.WAIT_CYCLES(WAIT_CYCLES)) u_i_port (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (i_req_valid),
        .rsp_ready  (i_rsp_ready),
        .req_ready  (i_req_ready),
        .rsp_valid  (i_rsp_valid),
        .accept     (i_accept_s),
        .enter_resp (i_enter_resp_s)
    );

    mem_port_fsm #(.WAIT_CYCLES(WAIT_CYCLES)) u_d_port (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (d_req_valid),
        .rsp_ready  (d_rsp_ready),
        .req_ready  (d_req_ready),
        .rsp_valid  (d_rsp_valid),
        .accept     (d_accept_s),
        .enter_resp (d_enter_resp_s)
    );

    // Capture the fetch address when a fetch is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_addr_r <= {ADDRSIZE{1'b0}};
        end else if (i_accept_s) begin
            i_addr_r <= i_addr;
        end
    end

    // With zero wait states the access happens on the accept edge, so use the live address
    always_comb begin
        if (i_accept_s) begin
            i_acc_addr_s = i_addr;
        end else begin
            i_acc_addr_s = i_addr_r;
        end
    end

    // Sample the instruction array on entry to RESP and hold until the next access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_rdata_r <= {WIDTH{1'b0}};
        end else if (i_enter_resp_s) begin
            i_rdata_r <= i_mem[i_acc_addr_s];
        end
    end

    // Capture the data request fields when a data access is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_addr_r  <= {ADDRSIZE{1'b0}};
            d_we_r    <= 1'b0;
            d_wdata_r <= {WIDTH{1'b0}};
`ifdef HMEM_BYTE_WRITE_EN
            d_be_r    <= {NB{1'b0}};
`endif
        end else if (d_accept_s) begin
            d_addr_r  <= d_addr;
            d_we_r    <= d_we;
            d_wdata_r <= d_wdata;
`ifdef HMEM_BYTE_WRITE_EN
            d_be_r    <= d_be;
`endif
        end
    end

    // Select live or latched request fields and form the word to be written
    always_comb begin
        if (d_accept_s) begin
            d_acc_addr_s  = d_addr;
            d_acc_we_s    = d_we;
            d_acc_wdata_s = d_wdata;
        end else begin
            d_acc_addr_s  = d_addr_r;
            d_acc_we_s    = d_we_r;
            d_acc_wdata_s = d_wdata_r;
        end
`ifdef HMEM_BYTE_WRITE_EN
        if (d_accept_s) begin
            d_acc_be_s = d_be;
        end else begin
            d_acc_be_s = d_be_r;
        end
        d_wr_word_s = merge_bytes(d_mem[d_acc_addr_s], d_acc_wdata_s, d_acc_be_s);
`else
        d_wr_word_s = d_acc_wdata_s;
`endif
    end

    // Commit a data write on entry to RESP; array contents survive reset
    always_ff @(posedge clk) begin
        if (!rst && d_enter_resp_s && d_acc_we_s) begin
            d_mem[d_acc_addr_s] <= d_wr_word_s;
        end
    end

    // Data read result on entry to RESP; writes respond with zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_rdata_r <= {WIDTH{1'b0}};
        end else if (d_enter_resp_s) begin
            if (d_acc_we_s) begin
                d_rdata_r <= {WIDTH{1'b0}};
            end else begin
                d_rdata_r <= d_mem[d_acc_addr_s];
            end
        end
    end

    assign i_rdata = i_rdata_r;
    assign d_rdata = d_rdata_r;

endmodule

// File: tb/tb_harvard_mem_ctrl.sv
// Self-checking bench for harvard_mem_ctrl: table-driven port accesses with
// a per-port scoreboard queue, plus sequences for stall, concurrent access,
// mid-access reset and (with HMEM_BYTE_WRITE_EN) byte-enabled writes.
module tb_harvard_mem_ctrl;

    localparam int W  = 32;
    localparam int A  = 12;
    localparam int WC = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         i_req_valid, i_req_ready, i_rsp_valid, i_rsp_ready;
    logic [A-1:0] i_addr;
    logic [W-1:0] i_rdata;
    logic         d_req_valid, d_req_ready, d_rsp_valid, d_rsp_ready, d_we;
    logic [A-1:0] d_addr;
    logic [W-1:0] d_wdata, d_rdata;
`ifdef HMEM_BYTE_WRITE_EN
    logic [W/8-1:0] d_be_v;
`endif

    int cmp_cnt = 0;
    int err_cnt = 0;
    logic [W-1:0] i_q[$];
    logic [W-1:0] d_q[$];

    typedef struct {
        logic         we;
        logic [A-1:0] addr;
        logic [W-1:0] wdata;
        logic [W-1:0] exp;
    } vec_t;

    vec_t dv[8];
    vec_t iv[4];

    always #5 clk = ~clk;

    harvard_mem_ctrl #(.WIDTH(W), .ADDRSIZE(A), .WAIT_CYCLES(WC)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req_valid (i_req_valid),
        .i_req_ready (i_req_ready),
        .i_addr      (i_addr),
        .i_rsp_valid (i_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .i_rdata     (i_rdata),
        .d_req_valid (d_req_valid),
        .d_req_ready (d_req_ready),
        .d_addr      (d_addr),
        .d_we        (d_we),
        .d_wdata     (d_wdata),
`ifdef HMEM_BYTE_WRITE_EN
        .d_be        (d_be_v),
`endif
        .d_rsp_valid (d_rsp_valid),
        .d_rsp_ready (d_rsp_ready),
        .d_rdata     (d_rdata)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Scoreboard: compare each consumed fetch response with the oldest expectation
    always @(negedge clk) begin
        if (!rst && i_rsp_valid && i_rsp_ready) begin
            if (i_q.size() == 0) begin
                cmp_cnt++;
                err_cnt++;
                $display("FAIL i_scoreboard: got unexpected response %h, required none", i_rdata);
            end else begin
                check("i_rdata", i_rdata, i_q.pop_front());
            end
        end
    end

    // Scoreboard: compare each consumed data response with the oldest expectation
    always @(negedge clk) begin
        if (!rst && d_rsp_valid && d_rsp_ready) begin
            if (d_q.size() == 0) begin
                cmp_cnt++;
                err_cnt++;
                $display("FAIL d_scoreboard: got unexpected response %h, required none", d_rdata);
            end else begin
                check("d_rdata", d_rdata, d_q.pop_front());
            end
        end
    end

    task automatic i_req(input logic [A-1:0] a, input logic [W-1:0] exp);
        check("i_req_ready_idle", W'(i_req_ready), W'(1));
        i_q.push_back(exp);
        i_addr = a;
        i_req_valid = 1'b1;
        @(posedge clk);
        #1 i_req_valid = 1'b0;
    endtask

    task automatic d_req(input logic we, input logic [A-1:0] a, input logic [W-1:0] wd,
                         input bit track, input logic [W-1:0] exp);
        check("d_req_ready_idle", W'(d_req_ready), W'(1));
        if (track) d_q.push_back(exp);
        d_we = we;
        d_addr = a;
        d_wdata = wd;
        d_req_valid = 1'b1;
        @(posedge clk);
        #1 d_req_valid = 1'b0;
    endtask

    // Wait for a response on one port (0 = fetch, 1 = data); lat counts edges after accept
    task automatic wait_rsp(input bit port_d, output int lat);
        logic v;
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
            v = port_d ? d_rsp_valid : i_rsp_valid;
            if (!v) check(port_d ? "d_req_ready_busy" : "i_req_ready_busy",
                          W'(port_d ? d_req_ready : i_req_ready), W'(0));
        end while (!v && lat < 40);
        if (!v) begin
            cmp_cnt++;
            err_cnt++;
            $display("FAIL %s_timeout: got no response after %0d cycles, required one", port_d ? "d" : "i", lat);
        end
    endtask

    task automatic i_txn(input logic [A-1:0] a, input logic [W-1:0] exp);
        int lat;
        i_req(a, exp);
        wait_rsp(1'b0, lat);
        check("i_latency", W'(lat), W'(WC + 1));
        @(posedge clk);
        #1;
    endtask

    task automatic d_txn(input logic we, input logic [A-1:0] a, input logic [W-1:0] wd, input logic [W-1:0] exp);
        int lat;
        d_req(we, a, wd, 1'b1, exp);
        wait_rsp(1'b1, lat);
        check("d_latency", W'(lat), W'(WC + 1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        i_req_valid = 1'b0; i_addr = '0; i_rsp_ready = 1'b1;
        d_req_valid = 1'b0; d_addr = '0; d_we = 1'b0; d_wdata = '0; d_rsp_ready = 1'b1;
`ifdef HMEM_BYTE_WRITE_EN
        d_be_v = '1;
`endif
        dut.i_mem[5]    = 32'hDEADBEEF;
        dut.i_mem[0]    = 32'h00000013;
        dut.i_mem[4095] = 32'hFFFF0000;
        dut.i_mem[100]  = 32'h01234567;
        dut.i_mem[7]    = 32'hC001D00D;

        dv[0] = '{1'b1, 12'd9,    32'h12345678, 32'h00000000};
        dv[1] = '{1'b0, 12'd9,    32'h00000000, 32'h12345678};
        dv[2] = '{1'b1, 12'd0,    32'hFFFFFFFF, 32'h00000000};
        dv[3] = '{1'b1, 12'd4095, 32'hA5A55A5A, 32'h00000000};
        dv[4] = '{1'b0, 12'd0,    32'h00000000, 32'hFFFFFFFF};
        dv[5] = '{1'b0, 12'd4095, 32'h00000000, 32'hA5A55A5A};
        dv[6] = '{1'b1, 12'd9,    32'h0BADF00D, 32'h00000000};
        dv[7] = '{1'b0, 12'd9,    32'h00000000, 32'h0BADF00D};

        iv[0] = '{1'b0, 12'd5,    32'h0, 32'hDEADBEEF};
        iv[1] = '{1'b0, 12'd0,    32'h0, 32'h00000013};
        iv[2] = '{1'b0, 12'd4095, 32'h0, 32'hFFFF0000};
        iv[3] = '{1'b0, 12'd100,  32'h0, 32'h01234567};

        // Reset state with the clock running
        repeat (3) @(posedge clk);
        #1;
        check("rst_i_req_ready", W'(i_req_ready), W'(1));
        check("rst_i_rsp_valid", W'(i_rsp_valid), W'(0));
        check("rst_i_rdata",     i_rdata,         W'(0));
        check("rst_d_req_ready", W'(d_req_ready), W'(1));
        check("rst_d_rsp_valid", W'(d_rsp_valid), W'(0));
        check("rst_d_rdata",     d_rdata,         W'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Fetch table (first row is addr 5 -> DEADBEEF, latency 3)
        for (int k = 0; k < 4; k++) i_txn(iv[k].addr, iv[k].exp);

        // Data table: writes, read-back, address extremes, overwrite
        for (int k = 0; k < 8; k++) d_txn(dv[k].we, dv[k].addr, dv[k].wdata, dv[k].exp);

        // Stalled fetch response: valid/data held, no new request accepted
        i_rsp_ready = 1'b0;
        i_req(12'd7, 32'hC001D00D);
        wait_rsp(1'b0, lat);
        check("stall_latency", W'(lat), W'(WC + 1));
        i_req_valid = 1'b1;
        i_addr = 12'd5;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("stall_i_rsp_valid", W'(i_rsp_valid), W'(1));
            check("stall_i_rdata",     i_rdata,         32'hC001D00D);
            check("stall_i_req_ready", W'(i_req_ready), W'(0));
        end
        i_req_valid = 1'b0;
        i_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall_release_valid", W'(i_rsp_valid), W'(0));
        check("stall_release_ready", W'(i_req_ready), W'(1));

        // Concurrent fetch and data read accepted on the same edge
        i_q.push_back(32'h01234567);
        d_q.push_back(32'h0BADF00D);
        i_addr = 12'd100; i_req_valid = 1'b1;
        d_addr = 12'd9; d_we = 1'b0; d_req_valid = 1'b1;
        @(posedge clk);
        #1 i_req_valid = 1'b0; d_req_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!(i_rsp_valid || d_rsp_valid) && lat < 40);
        check("dual_latency",   W'(lat),         W'(WC + 1));
        check("dual_i_valid",   W'(i_rsp_valid), W'(1));
        check("dual_d_valid",   W'(d_rsp_valid), W'(1));
        @(posedge clk);
        #1;

        // Reset during the wait states of a write: write must be dropped
        d_txn(1'b1, 12'd3, 32'h00000000, 32'h00000000);
        d_txn(1'b0, 12'd9, 32'h00000000, 32'h0BADF00D);
        i_txn(12'd5, 32'hDEADBEEF);
        d_req(1'b1, 12'd3, 32'hCAFEF00D, 1'b0, 32'h0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_d_req_ready", W'(d_req_ready), W'(1));
        check("midrst_d_rsp_valid", W'(d_rsp_valid), W'(0));
        check("midrst_d_rdata",     d_rdata,         W'(0));
        check("midrst_i_req_ready", W'(i_req_ready), W'(1));
        check("midrst_i_rdata",     i_rdata,         W'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        d_txn(1'b0, 12'd3, 32'h00000000, 32'h00000000);

`ifdef HMEM_BYTE_WRITE_EN
        // Byte-enabled write updates only the selected lanes
        d_be_v = 4'hF;
        d_txn(1'b1, 12'd20, 32'hAABBCCDD, 32'h00000000);
        d_be_v = 4'b0101;
        d_txn(1'b1, 12'd20, 32'h11223344, 32'h00000000);
        d_be_v = 4'hF;
        d_txn(1'b0, 12'd20, 32'h00000000, 32'hAA22CC44);
`endif

        repeat (2) @(posedge clk);
        #1;
        check("i_queue_drained", W'(i_q.size()), W'(0));
        check("d_queue_drained", W'(d_q.size()), W'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
